// File: rtl/pc_sequencer.sv
// Program-counter sequencer: hold / increment / conditional relative branch / absolute jump,
// with stall and an optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int OFF_W     = 6,
    parameter int DR_W      = 3,
    parameter int SB_W      = 3,
    parameter int RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        ps,
    input  logic              cond,
    input  logic [DR_W-1:0]   dr,
    input  logic [SB_W-1:0]   sb,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] address,
    output logic              ras_empty,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    typedef enum logic [1:0] {
        PS_HOLD   = 2'b00,
        PS_INC    = 2'b01,
        PS_BRANCH = 2'b10,
        PS_JUMP   = 2'b11
    } ps_e;

    if ((OFF_W != DR_W + SB_W) || (OFF_W > ADDR_W) || (RAS_DEPTH < 2) ||
        ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_params
        $error("pc_sequencer: inconsistent parameters");
    end

    logic [ADDR_W-1:0]       pc;
    logic [ADDR_W-1:0]       pc_next;
    logic [ADDR_W-1:0]       pc_inc;
    logic signed [OFF_W-1:0] offset;
    logic [ADDR_W-1:0]       offset_ext;

    assign pc_inc     = pc + ADDR_W'(1);
    assign offset     = {dr, sb};
    assign offset_ext = ADDR_W'(offset);
    assign address    = pc;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0]  top;
    logic [PTR_W-1:0]  top_prev;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              overflow;
    logic              underflow;

    // top is the next free slot; when full it also indexes the oldest entry,
    // so a push there overwrites the oldest return address.
    assign top_prev = top - PTR_W'(1);
    assign full     = (count == (PTR_W + 1)'(RAS_DEPTH));
    assign empty    = (count == '0);

    always_comb begin
        pc_next = pc;
        push    = 1'b0;
        pop     = 1'b0;
        if (stall) begin
            pc_next = pc;
        end else if (ret) begin
            pop     = 1'b1;
            pc_next = empty ? pc_inc : stack[top_prev];
        end else begin
            case (ps_e'(ps))
                PS_JUMP: begin
                    pc_next = jump_target;
                    push    = call;
                end
                PS_BRANCH: pc_next = cond ? pc + offset_ext : pc_inc;
                PS_INC:    pc_next = pc_inc;
                default:   pc_next = pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_VEC;
            top       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc <= pc_next;
            if (push) begin
                top <= top + PTR_W'(1);
                if (full) overflow <= 1'b1;
                else      count    <= count + (PTR_W + 1)'(1);
            end else if (pop) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    top   <= top_prev;
                    count <= count - (PTR_W + 1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) stack[top] <= pc_inc;
    end

    assign ras_empty     = empty;
    assign ras_overflow  = overflow;
    assign ras_underflow = underflow;
`else
    logic unused_call;
    assign unused_call = call;

    always_comb begin
        pc_next = pc;
        if (stall) begin
            pc_next = pc;
        end else if (ret) begin
            pc_next = pc_inc;
        end else begin
            case (ps_e'(ps))
                PS_JUMP:   pc_next = jump_target;
                PS_BRANCH: pc_next = cond ? pc + offset_ext : pc_inc;
                PS_INC:    pc_next = pc_inc;
                default:   pc_next = pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= RESET_VEC;
        else       pc <= pc_next;
    end

    assign ras_empty     = 1'b1;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; stack checks apply when PC_RAS_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  ps;
    logic        cond;
    logic [2:0]  dr;
    logic [2:0]  sb;
    logic [15:0] jump_target;
    logic        call;
    logic        ret;
    logic [15:0] address;
    logic        ras_empty;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .ADDR_W(16), .OFF_W(6), .DR_W(3), .SB_W(3), .RAS_DEPTH(4), .RESET_VEC(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .ps(ps), .cond(cond), .dr(dr), .sb(sb),
        .jump_target(jump_target), .call(call), .ret(ret), .address(address),
        .ras_empty(ras_empty), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 1'b0; ps = 2'b00; cond = 1'b0; dr = '0; sb = '0;
        jump_target = '0; call = 1'b0; ret = 1'b0;
    endtask

    // Apply current inputs across one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [15:0] t);
        idle(); ps = 2'b11; jump_target = t; step(); idle();
    endtask

    task automatic flags(input string tag, input logic e, input logic o, input logic u);
        check({tag, "_empty"}, 32'(ras_empty), 32'(e));
        check({tag, "_ovf"},   32'(ras_overflow), 32'(o));
        check({tag, "_unf"},   32'(ras_underflow), 32'(u));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        check("reset_addr", 32'(address), 32'h0000);
        flags("reset", 1'b1, 1'b0, 1'b0);

        @(negedge clk); reset = 1'b0; ps = 2'b01;
        step(); check("inc1", 32'(address), 32'h0001);
        step(); check("inc2", 32'(address), 32'h0002);
        step(); check("inc3", 32'(address), 32'h0003);

        @(negedge clk); reset = 1'b1;
        #1; check("async_reset", 32'(address), 32'h0000);
        #1; reset = 1'b0; idle();
        step(); check("hold_after_reset", 32'(address), 32'h0000);

        jump(16'h0010); check("jump_10", 32'(address), 32'h0010);
        ps = 2'b10; cond = 1'b1; dr = 3'b111; sb = 3'b110;
        step(); check("branch_neg2", 32'(address), 32'h000E);
        cond = 1'b0;
        step(); check("branch_not_taken", 32'(address), 32'h000F);
        jump(16'h0010);
        ps = 2'b10; cond = 1'b0; dr = 3'b111; sb = 3'b110;
        step(); check("branch_nt_0x10", 32'(address), 32'h0011);
        cond = 1'b1; dr = 3'b011; sb = 3'b111;
        step(); check("branch_pos31", 32'(address), 32'h0030);
        cond = 1'b1; dr = 3'b100; sb = 3'b000;
        step(); check("branch_neg32", 32'(address), 32'h0010);

        jump(16'hFFFF); check("jump_ffff", 32'(address), 32'hFFFF);
        ps = 2'b01;
        step(); check("inc_wrap", 32'(address), 32'h0000);
        ps = 2'b10; cond = 1'b1; dr = 3'b111; sb = 3'b110;
        step(); check("branch_wrap_below0", 32'(address), 32'hFFFE);
        idle();
        step(); check("hold_ps00", 32'(address), 32'hFFFE);
        stall = 1'b1; ps = 2'b11; call = 1'b1; jump_target = 16'h1234;
        step(); check("stall_hold", 32'(address), 32'hFFFE);
        flags("stall", 1'b1, 1'b0, 1'b0);
        stall = 1'b1; ps = 2'b01; ret = 1'b1;
        step(); check("stall_over_ret", 32'(address), 32'hFFFE);
        idle();

`ifdef PC_RAS_EN
        jump(16'h0100);
        ps = 2'b11; call = 1'b1; jump_target = 16'h0200;
        step(); check("call_200", 32'(address), 32'h0200);
        check("call_not_empty", 32'(ras_empty), 32'(1'b0));
        idle(); ret = 1'b1;
        step(); check("ret_101", 32'(address), 32'h0101);
        flags("ret", 1'b1, 1'b0, 1'b0);

        idle(); ps = 2'b01; call = 1'b1;
        step(); check("call_without_jump", 32'(address), 32'h0102);
        check("call_without_jump_empty", 32'(ras_empty), 32'(1'b1));

        idle(); ps = 2'b11; call = 1'b1; jump_target = 16'h0300;
        step(); check("call_300", 32'(address), 32'h0300);
        stall = 1'b1; ret = 1'b1;
        step(); check("stall_call_ret", 32'(address), 32'h0300);
        flags("stall_ras", 1'b0, 1'b0, 1'b0);
        stall = 1'b0; ret = 1'b1; call = 1'b1; ps = 2'b11; jump_target = 16'h0400;
        step(); check("ret_wins", 32'(address), 32'h0103);
        flags("ret_wins", 1'b1, 1'b0, 1'b0);

        jump(16'h0000);
        for (int i = 1; i <= 5; i++) begin
            ps = 2'b11; call = 1'b1; jump_target = 16'(i * 16);
            step();
            check("nest_call", 32'(address), 32'(i * 16));
        end
        idle();
        flags("nest", 1'b0, 1'b1, 1'b0);
        ret = 1'b1;
        step(); check("pop_41", 32'(address), 32'h0041);
        step(); check("pop_31", 32'(address), 32'h0031);
        step(); check("pop_21", 32'(address), 32'h0021);
        step(); check("pop_11", 32'(address), 32'h0011);
        check("pop_unf_clear", 32'(ras_underflow), 32'(1'b0));
        step(); check("pop_underflow", 32'(address), 32'h0012);
        flags("underflow", 1'b1, 1'b1, 1'b1);
        idle();
        ps = 2'b11; call = 1'b1; jump_target = 16'h0500;
        step(); ps = 2'b00; call = 1'b0; ret = 1'b1;
        step(); check("call_ret_back2back", 32'(address), 32'h0013);
        idle();
`else
        jump(16'h0100);
        ps = 2'b11; call = 1'b1; jump_target = 16'h0200;
        step(); check("call_plain_jump", 32'(address), 32'h0200);
        flags("no_ras_call", 1'b1, 1'b0, 1'b0);
        ps = 2'b11; call = 1'b1; ret = 1'b1; jump_target = 16'h0700;
        step(); check("ret_is_inc", 32'(address), 32'h0201);
        idle(); ret = 1'b1;
        step(); check("ret_is_inc2", 32'(address), 32'h0202);
        step(); check("ret_is_inc3", 32'(address), 32'h0203);
        flags("no_ras_ret", 1'b1, 1'b0, 1'b0);
        idle();
`endif

        @(negedge clk); reset = 1'b1;
        #1; check("final_reset_addr", 32'(address), 32'h0000);
        flags("final_reset", 1'b1, 1'b0, 1'b0);
        #1; reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer and next-generation replacement for the CPU's fixed 16-bit PC. It holds the instruction address, and each clock it advances, branches relative, or jumps absolute under the control word's PS field. It adds a stall input, conditional branching, and an optional hardware return-address stack (RAS) for call/return. It sits between control logic and instruction memory; `address` drives the instruction-memory address bus directly.

## Interface
- `ADDR_W`, 16: PC/address width in bits.
- `OFF_W`, 6: branch offset width; offset is `{dr, sb}`, so it must equal `DR_W + SB_W`.
- `DR_W`, 3: width of the `dr` field.
- `SB_W`, 3: width of the `sb` field.
- `RAS_DEPTH`, 4: return-address stack entries, minimum 2, power of two.
- `RESET_VEC`, 0: PC value loaded on reset.

- `clk`  in  1  sole clock; rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  when 1, PC and stack hold regardless of all other inputs.
- `ps`  in  2  PC select: 00 hold, 01 increment, 10 conditional relative branch, 11 absolute jump.
- `cond`  in  1  branch-taken condition, used only when `ps`=10.
- `dr`  in  DR_W  upper offset field.
- `sb`  in  SB_W  lower offset field.
- `jump_target`  in  ADDR_W  absolute target for `ps`=11.
- `call`  in  1  with `ps`=11, push return address (PC+1) and jump.
- `ret`  in  1  pop the stack into PC; overrides `ps`.
- `address`  out  ADDR_W  current PC.
- `ras_empty`  out  1  stack holds no entries.
- `ras_overflow`  out  1  sticky: a push occurred while the stack was full.
- `ras_underflow`  out  1  sticky: a pop occurred while the stack was empty.

## Operation
- Next-PC priority, highest first:
  1. `stall`: hold.
  2. `ret`: pop.
  3. `ps`=11: jump, plus push if `call`.
  4. `ps`=10: branch.
  5. `ps`=01: increment.
  6. `ps`=00: hold.
- Branch: if `cond`=1, PC <= PC + sign_extend({dr,sb}) to ADDR_W; if `cond`=0, PC <= PC+1.
- All arithmetic is modulo 2^ADDR_W. PC = all-ones incremented gives 0; negative offsets wrap below 0.
- `call` with `ps`≠11 is ignored; no push occurs.
- `call` and `ret` asserted together: `ret` wins and no push occurs.
- Stack is a circular buffer with pointer and count.
- Push when full: the oldest entry is overwritten, count stays at RAS_DEPTH, and `ras_overflow` sets.
- Pop when empty: PC <= PC+1, the stack is unchanged, and `ras_underflow` sets.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous): PC = RESET_VEC, stack count = 0, `ras_empty`=1, both flags = 0. Stack contents are undefined.
- Reset asserted mid-operation aborts any push or pop immediately.
- `address` equals the PC register, with no combinational path from inputs.
- Single-cycle latency: inputs sampled at edge N appear on `address` after edge N.
- Stack and flags update on the same edge as PC.
- A pop returns the value pushed on the most recent unpopped call, one edge after `ret`.
- Back-to-back call/ret on consecutive cycles is supported with no bubble.
- `ras_empty` is registered state: it reflects the count after the last edge.

## Configuration
- `PC_RAS_EN` defined: the return-address stack and flags are implemented as above.
- `PC_RAS_EN` undefined:
  - No stack storage.
  - `call` is ignored, so `ps`=11 is a plain jump.
  - `ret` acts as increment.
  - `ras_empty` is tied to 1; `ras_overflow` and `ras_underflow` are tied to 0.

## Test plan
- Reset then `ps`=01 for 3 cycles: `address` goes 0x0000, 0x0001, 0x0002, 0x0003. Assert `reset` mid-sequence: `address`=0x0000 immediately, without waiting for a clock edge.
- PC=0x0010, `ps`=10, `cond`=1, `dr`=3'b111, `sb`=3'b110 (offset -2): PC=0x000E. Same with `cond`=0: PC=0x0011. PC=0xFFFF with `ps`=01: PC=0x0000.
- PC=0x0100, `ps`=11, `call`=1, `jump_target`=0x0200: PC=0x0200. Then `ret`: PC=0x0101 and `ras_empty`=1.
- RAS_DEPTH=4, five nested calls: `ras_overflow`=1. Five returns yield return addresses 5, 4, 3, 2, then underflow with PC+1 and `ras_underflow`=1.
- `stall`=1 with `ps`=11, `call`=1: PC, stack and flags are unchanged. Same cycle with `stall`=0 and `ret`=1 and `call`=1: pop only, no push.
- Build without `PC_RAS_EN`: `call` with `ps`=11 jumps to target, `ret` increments, and flags stay 0.
